t02_ram_responder: RTL and testbench
====================================

# t02_ram_responder

Single-port word-addressed memory responder that serves the request unit's RAM bus (`Ren`/`Wen`, `ramaddr`, `ramstore`, `ramload`, `busy_o`). It sits on the far side of that bus in place of the external RAM. It is used for simulation and FPGA bring-up of the team_02 core. It latches one request at a time, stalls the requester for a programmable number of cycles, then commits the write or returns the read word and signals completion by dropping `busy_o`.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥4.
- `LATENCY`, 2: number of WAIT cycles per access; ≥1.
- `ADDR_W`, $clog2(DEPTH_WORDS): word-index width (derived).

Ports:
- `clk` in 1: the single clock. All state is updated on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `Ren` in 1: read request.
- `Wen` in 1: write request. Takes priority over `Ren` when both are high.
- `ramaddr` in 32: byte address. Bits [1:0] are ignored.
- `ramstore` in 32: write data.
- `ramload` out 32: read data. Registered.
- `busy_o` out 1: transaction in progress (requester stall).
- `err_o` out 1: sticky flag set by an out-of-range access. Cleared only by reset.

## Operation
- Word index is `ramaddr[ADDR_W+1:2]`. An address is out of range if any bit of `ramaddr[31:ADDR_W+2]` is non-zero.
- FSM states: IDLE, WAIT, DONE.
- **IDLE**:
  - `busy_o = Ren | Wen` (combinational), so the requester never sees a false completion.
  - On a clock edge with `Ren | Wen` high: latch op (write if `Wen`, else read), word index, `ramstore` and the range flag. Load the counter with `LATENCY-1` and go to WAIT.
- **WAIT**:
  - `busy_o = 1`. Bus inputs are ignored; only the latched values are used.
  - Counter decrements each cycle. When it reaches 0, perform the access and go to DONE.
    - Write, in range: `mem[idx] <= latched data`.
    - Read, in range: `ramload <= mem[idx]`.
    - Out of range: write is dropped; read loads `ramload <= 0`. In both cases `err_o <= 1`.
- **DONE**:
  - `busy_o = 0`. Requests are ignored this cycle. Unconditionally go to IDLE next cycle.
  - If the requester still holds `Ren`/`Wen` in IDLE, a new transaction starts; duplicates are the requester's responsibility.
- `ramload` holds its value until the next read completes. Writes do not change it.
- Reset (asynchronous, any state): state=IDLE, counter=0, `ramload`=0, `err_o`=0, latches=0. Memory contents are not affected by reset.
- Reset in the middle of a transaction aborts it. A pending write is not committed.

## Timing
- Request sampled at the edge ending cycle 0 (IDLE, `busy_o` already 1 combinationally).
- Cycles 1..`LATENCY`: WAIT, `busy_o`=1.
- The access occurs at the edge ending cycle `LATENCY`.
- Cycle `LATENCY+1`: DONE, `busy_o`=0.
  - Read data is valid on `ramload` from this cycle onward.
  - A write is visible to a read issued from this cycle onward.
- Total per transaction: `LATENCY+2` cycles from request to earliest next sample.
- Back-to-back requests are therefore spaced ≥`LATENCY+2` cycles apart.
- Write-then-read of the same address returns the new data.

## Test plan
1. **Reset.** Assert `nrst`=0 mid-WAIT with `Wen`=1, addr 0x10, data 0xDEADBEEF. Then read 0x10.
   - Expect: `busy_o`=0, `ramload`=0, `err_o`=0 immediately.
   - Expect: the read returns the prior contents, not 0xDEADBEEF.
2. **Write then read.** `LATENCY`=2. Write 0xCAFEF00D to 0x40, then read 0x40.
   - Expect: `busy_o` high for cycles 0–2 of each transaction and low in cycle 3.
   - Expect: `ramload`=0xCAFEF00D in the read's cycle 3.
3. **Priority.** Assert `Ren`=`Wen`=1, addr 0x8, data 0x12345678.
   - Expect: a write occurs and `ramload` is unchanged.
   - Expect: a subsequent read of 0x8 returns 0x12345678.
4. **Input isolation.** Change `ramaddr`/`ramstore` during WAIT of a write to 0x4 with 0xAAAA5555.
   - Expect: the commit uses the latched values; a read of 0x4 returns 0xAAAA5555.
5. **Out of range.** `DEPTH_WORDS`=256. Read byte address 0x400.
   - Expect: `ramload`=0 and `err_o`=1, sticky.
   - Expect: a write to 0x400 does not alias to 0x0.
6. **Sustained requests.** Hold `Ren` high continuously on 0x0.
   - Expect: transactions repeat every `LATENCY+2` cycles.
   - Expect: `busy_o` low exactly one cycle per transaction.

Source files
------------

// File: rtl/t02_ram_responder_if.sv
// RAM bus between the request unit (master) and the memory responder (slave).
interface t02_ram_responder_if;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        busy_o;
  logic        err_o;

  modport master (
    output Ren, Wen, ramaddr, ramstore,
    input  ramload, busy_o, err_o
  );

  modport slave (
    input  Ren, Wen, ramaddr, ramstore,
    output ramload, busy_o, err_o
  );
endinterface

// File: rtl/t02_ram_responder.sv
// Word-addressed RAM responder: latches one request, stalls for LATENCY cycles,
// then commits the write or returns the read word and drops busy for one cycle.
module t02_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  t02_ram_responder_if.slave    bus
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic                oor_q, oor_d;
  logic [31:0]         ramload_q, ramload_d;
  logic                err_q, err_d;
  logic                busy;
  logic                mem_we;
  logic                req_oor;
  logic                unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_oor     = |bus.ramaddr[31:ADDR_W+2];
  assign unused_addr = ^bus.ramaddr[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    data_d    = data_q;
    oor_d     = oor_q;
    ramload_d = ramload_q;
    err_d     = err_q;
    busy      = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Busy follows the request combinationally so no false completion is seen.
        busy = bus.Ren | bus.Wen;
        if (busy) begin
          wr_d    = bus.Wen;
          idx_d   = bus.ramaddr[ADDR_W+1:2];
          data_d  = bus.ramstore;
          oor_d   = req_oor;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
          if (oor_q) begin
            err_d = 1'b1;
            if (!wr_q) ramload_d = '0;
          end else if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            ramload_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      oor_q     <= 1'b0;
      ramload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      oor_q     <= oor_d;
      ramload_q <= ramload_d;
      err_q     <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain; reset only aborts the commit.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= data_q;
  end

  assign bus.busy_o  = busy;
  assign bus.ramload = ramload_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_t02_ram_responder.sv
// Self-checking bench for t02_ram_responder: vector table plus reset and
// sustained-request sequences, with expected responses queued at issue time.
module tb_t02_ram_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 2;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] data;
    bit          disturb;
    logic [31:0] exp_load;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic        err;
  } exp_t;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;
  vec_t vecs [13];
  exp_t sb [$];

  t02_ram_responder_if bus ();

  t02_ram_responder #(
    .DEPTH_WORDS (Depth),
    .LATENCY     (Lat)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                              input logic [31:0] data, input bit disturb,
                              input logic [31:0] exp_load, input logic exp_err);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.data = data; v.disturb = disturb;
    v.exp_load = exp_load; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic pop_and_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got load %h", name, bus.ramload);
    end else begin
      e = sb.pop_front();
      chk({name, " ramload"}, bus.ramload, e.load);
      chk({name, " err_o"}, 32'(bus.err_o), 32'(e.err));
    end
  endtask

  // Starts at posedge+1 with the responder in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_vec(input vec_t v);
    exp_t e;
    e.load = v.exp_load;
    e.err  = v.exp_err;
    bus.Wen = v.we; bus.Ren = v.re; bus.ramaddr = v.addr; bus.ramstore = v.data;
    sb.push_back(e);
    @(negedge clk) chk("busy c0", 32'(bus.busy_o), 32'd1);
    for (int c = 1; c <= int'(Lat); c++) begin
      @(posedge clk); #1;
      if (v.disturb) begin
        bus.ramaddr  = 32'h3c + 32'(c);
        bus.ramstore = ~v.data;
      end else begin
        bus.Wen = 1'b0; bus.Ren = 1'b0;
      end
      @(negedge clk) chk("busy wait", 32'(bus.busy_o), 32'd1);
    end
    @(posedge clk); #1;
    bus.Wen = 1'b0; bus.Ren = 1'b0; bus.ramaddr = '0; bus.ramstore = '0;
    @(negedge clk);
    chk("busy done", 32'(bus.busy_o), 32'd0);
    pop_and_check("done");
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   low_cnt;
    n_checks = 0;
    n_fail   = 0;
    nrst = 1'b0;
    bus.Ren = 1'b0; bus.Wen = 1'b0; bus.ramaddr = '0; bus.ramstore = '0;

    vecs[0]  = mk(1, 0, 32'h10,  32'h11111111, 0, 32'h0,        0);
    vecs[1]  = mk(1, 0, 32'h40,  32'hCAFEF00D, 0, 32'h0,        0);
    vecs[2]  = mk(0, 1, 32'h40,  32'h0,        0, 32'hCAFEF00D, 0);
    vecs[3]  = mk(1, 1, 32'h8,   32'h12345678, 0, 32'hCAFEF00D, 0);
    vecs[4]  = mk(0, 1, 32'h8,   32'h0,        0, 32'h12345678, 0);
    vecs[5]  = mk(1, 0, 32'h4,   32'hAAAA5555, 1, 32'h12345678, 0);
    vecs[6]  = mk(0, 1, 32'h4,   32'h0,        0, 32'hAAAA5555, 0);
    vecs[7]  = mk(1, 0, 32'h0,   32'h0BADC0DE, 0, 32'hAAAA5555, 0);
    // After the aborted write: reset clears ramload, memory keeps the old word.
    vecs[8]  = mk(0, 1, 32'h10,  32'h0,        0, 32'h11111111, 0);
    vecs[9]  = mk(0, 1, 32'h400, 32'h0,        0, 32'h0,        1);
    vecs[10] = mk(1, 0, 32'h400, 32'hFFFFFFFF, 0, 32'h0,        1);
    vecs[11] = mk(0, 1, 32'h0,   32'h0,        0, 32'h0BADC0DE, 1);
    vecs[12] = mk(0, 1, 32'h8,   32'h0,        0, 32'h12345678, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset ramload", bus.ramload, 32'h0);
    chk("reset err", 32'(bus.err_o), 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort a write to 0x10 in the first WAIT cycle.
    bus.Wen = 1'b1; bus.ramaddr = 32'h10; bus.ramstore = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.Wen = 1'b0;
    nrst = 1'b0;
    #1;
    chk("midreset busy", 32'(bus.busy_o), 32'd0);
    chk("midreset ramload", bus.ramload, 32'h0);
    chk("midreset err", 32'(bus.err_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 8; i < 13; i++) run_vec(vecs[i]);

    // Sustained read of 0x0: one transaction every Lat+2 cycles.
    low_cnt = 0;
    bus.Ren = 1'b1; bus.ramaddr = 32'h0;
    for (int k = 0; k < 3 * (int'(Lat) + 2); k++) begin
      if (k % (int'(Lat) + 2) == 0) begin
        e.load = 32'h0BADC0DE;
        e.err  = 1'b1;
        sb.push_back(e);
      end
      @(negedge clk);
      if (k % (int'(Lat) + 2) == int'(Lat) + 1) begin
        chk("sustain busy low", 32'(bus.busy_o), 32'd0);
        pop_and_check("sustain");
      end else begin
        chk("sustain busy high", 32'(bus.busy_o), 32'd1);
      end
      if (!bus.busy_o) low_cnt++;
      @(posedge clk); #1;
    end
    bus.Ren = 1'b0;
    chk("sustain low count", 32'(low_cnt), 32'd3);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
